calc_multidigit: RTL and testbench
==================================

// Module: calc_multidigit
// PURPOSE
//  Parametrised successor to the keypad calculator core: accepts one 4-bit key per valid strobe,
//  builds two unsigned decimal operands, executes + / - / x (x via iterative shift-add),
//  flags negative results and overflow, then scans the NDIG-digit result to the display ctrl.
// PARAMETERS
//  NDIG   8                   displayed decimal digits; max operand/result = 10**NDIG-1
//  W      $clog2(10**NDIG)    operand/result magnitude width (27 for NDIG=8)
//  PW     $clog2(NDIG)        width of pos
// PORTS
//  clock      in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-high
//  cmd        in   4   key: 0-9 digit, 10 add, 11 sub, 12 mul, 13 clear, 14 '=', 15 backspace
//  cmd_valid  in   1   cmd qualifier; one key consumed per cycle with cmd_valid & cmd_ready
//  cmd_ready  out  1   1 only in WAIT_A / WAIT_B / ERROR (not during CALC or SCAN)
//  status     out  2   00 error, 01 busy (CALC), 10 ready, 11 scanning display
//  data       out  4   BCD digit for display position pos; valid while status==11
//  pos        out  PW  display position, 0 = least significant digit
//  neg        out  1   displayed value is negative (magnitude on data)
//  state      out  3   current FSM state (debug)
// BEHAVIOUR
//  Reset (any time, incl. mid-CALC/SCAN): state=WAIT_A, A=B=acc=0, op=none, status=10,
//   data=0, pos=0, neg=0, cmd_ready=1. Keys with cmd_valid=0 or cmd_ready=0 are dropped.
//  States: WAIT_A, WAIT_B, CALC, SCAN, ERROR. Entry register E (A in WAIT_A, B in WAIT_B).
//  WAIT_A/WAIT_B:
//   - digit: if E has <NDIG digits, E=E*10+cmd, else key ignored (no error); then SCAN(E).
//   - 15: E=E/10, SCAN(E). 13: A=B=0, op=none, neg=0, ->WAIT_A, SCAN(0).
//   - 10/11/12 in WAIT_A: op=cmd, B=0, ->WAIT_B (no scan). In WAIT_B: replaces op, B kept.
//   - 14 in WAIT_B: ->CALC. 14 in WAIT_A: ignored.
//  CALC (status=01):
//   - add: 1 cycle, R=A+B. sub: 1 cycle; A>=B -> R=A-B,neg=0 else R=B-A,neg=1.
//   - mul: W+1 cycles, shift-add over B bits, accumulator W*2 bits wide.
//   - R>10**NDIG-1 -> ERROR. Else A=R (result chains as next A), B=0, ->SCAN(R) then WAIT_A.
//  Chaining: after result, op key applies to A=R (neg cleared: magnitude used);
//   digit key first clears A then enters digit.
//  SCAN: NDIG cycles, cycle k: pos=k, data=(V/10**k)%10, status=11; leading zeros driven as 0.
//   After last digit: pos=0, status=10, cmd_ready=1 next cycle, return to saved state.
//  ERROR: status=00, data=0, neg=0; only key 13 (->WAIT_A, status=10) or reset exits.
//  neg cleared by any digit/backspace/clear entry in WAIT_A.
//  Latency: key -> first scanned digit = 1 cycle (digit/backspace); add/sub '=' -> 2 cycles;
//   mul '=' -> W+2 cycles.
// STRUCTURE
//  calc_pkg: cmd code constants (KEY_ADD..KEY_BKSP), state_t enum, status_t codes
//   (ST_ERR/ST_BUSY/ST_READY/ST_SCAN).
//  Sub-module calc_mul_shiftadd (#(W)): start, a, b -> done, product[2W-1:0];
//   holds product until next start; cleared by reset.
//  Top: FSM + entry regs + SCAN divider chain (divide-by-10 register per scan step).
// TESTING (NDIG=8, W=27)
//  keys 1,2,add,3,4,'=' -> SCAN digits 6,4,0,0,0,0,0,0 at pos 0..7, neg=0, status 10 after.
//  keys 5,sub,9,'=' -> scan 4,0..., neg=1; then add,1,'=' -> result 5 (magnitude chained).
//  keys 1,2,3,4,mul,5,6,7,8,'=' -> status 01 for 28 cycles, cmd_ready=0, scan 7006652.
//  eight 9s, add, 1, '=' -> status 00, cmd_ready=1; key 13 -> status 10, state WAIT_A.
//  9 digits 1..9 entered -> only first 8 kept (12345678); backspace -> 1234567 scanned.
//  reset asserted mid-mul (cycle 10) -> next edge status=10, pos=0, state=WAIT_A; new add works.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared key codes, FSM states, status codes and operator type for the
// multi-digit keypad calculator.
package calc_pkg;

  localparam logic [3:0] KEY_ADD  = 4'd10;
  localparam logic [3:0] KEY_SUB  = 4'd11;
  localparam logic [3:0] KEY_MUL  = 4'd12;
  localparam logic [3:0] KEY_CLR  = 4'd13;
  localparam logic [3:0] KEY_EQ   = 4'd14;
  localparam logic [3:0] KEY_BKSP = 4'd15;

  typedef enum logic [2:0] {
    WAIT_A = 3'd0,
    WAIT_B = 3'd1,
    CALC   = 3'd2,
    SCAN   = 3'd3,
    ERROR  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ST_ERR   = 2'b00,
    ST_BUSY  = 2'b01,
    ST_READY = 2'b10,
    ST_SCAN  = 2'b11
  } status_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2,
    OP_MUL  = 2'd3
  } op_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic op_t key_to_op(input logic [3:0] k);
    case (k)
      KEY_ADD: return OP_ADD;
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/calc_mul_shiftadd.sv
// Iterative shift-add multiplier: W iterations after start, one multiplier
// bit per cycle. Product and done hold until the next start.
module calc_mul_shiftadd #(
  parameter int W = 27
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] acc_reg;
  logic [2*W-1:0] mcand_reg;
  logic [W-1:0]   mplier_reg;
  logic [CW-1:0]  cnt_reg;
  logic           busy_reg;
  logic           done_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else if (start) begin
      acc_reg    <= '0;
      mcand_reg  <= {{W{1'b0}}, a};
      mplier_reg <= b;
      cnt_reg    <= CW'(W);
      busy_reg   <= 1'b1;
      done_reg   <= 1'b0;
    end else if (busy_reg) begin
      if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg - CW'(1);
      if (cnt_reg == CW'(1)) begin
        busy_reg <= 1'b0;
        done_reg <= 1'b1;
      end
    end
  end

  assign done    = done_reg;
  assign product = acc_reg;

endmodule

// File: rtl/calc_multidigit.sv
// Multi-digit keypad calculator core: operand entry, add/sub/mul with
// overflow detection, and a digit-serial scan of the result to the display.
module calc_multidigit
  import calc_pkg::*;
#(
  parameter int NDIG = 8,
  parameter int W    = $clog2(10**NDIG),
  parameter int PW   = $clog2(NDIG)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  output logic [1:0]    status,
  output logic [3:0]    data,
  output logic [PW-1:0] pos,
  output logic          neg,
  output logic [2:0]    state
);

  localparam int            W2       = 2 * W;
  localparam logic [W-1:0]  TEN      = W'(10);
  localparam logic [W-1:0]  MAX_VAL  = W'(10**NDIG - 1);
  localparam logic [W-1:0]  DIG_LIM  = W'(10**(NDIG - 1));
  localparam logic [PW-1:0] LAST_POS = PW'(NDIG - 1);

  state_t        state_reg, state_next;
  state_t        ret_reg, ret_next;
  op_t           op_reg, op_next;
  logic [W-1:0]  a_reg, a_next;
  logic [W-1:0]  b_reg, b_next;
  logic [W-1:0]  scan_val_reg, scan_val_next;
  logic [PW-1:0] pos_reg, pos_next;
  logic          neg_reg, neg_next;
  logic          fresh_reg, fresh_next;

  logic          key_fire;
  logic          in_wait_a;
  logic [W-1:0]  entry, entry_base, entry_new;
  logic [W:0]    sum;
  logic [W-1:0]  diff;
  logic [W2-1:0] product, res_wide;
  logic          res_neg, res_ok;
  logic          mul_start, mul_done;
  status_t       status_c;

  calc_mul_shiftadd #(.W(W)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (a_reg),
    .b       (b_reg),
    .done    (mul_done),
    .product (product)
  );

  assign cmd_ready = (state_reg == WAIT_A) || (state_reg == WAIT_B) || (state_reg == ERROR);
  assign key_fire  = cmd_valid & cmd_ready;
  assign in_wait_a = (state_reg == WAIT_A);

  // A fresh result in A is replaced, not extended, by the next digit.
  assign entry      = in_wait_a ? a_reg : b_reg;
  assign entry_base = (in_wait_a && fresh_reg) ? '0 : entry;
  assign entry_new  = !is_digit(cmd)         ? entry / TEN :
                      (entry_base < DIG_LIM) ? entry_base * TEN + W'(cmd) :
                                               entry_base;

  assign sum  = {1'b0, a_reg} + {1'b0, b_reg};
  assign diff = (a_reg >= b_reg) ? a_reg - b_reg : b_reg - a_reg;

  always_comb begin
    res_wide = '0;
    res_neg  = 1'b0;
    res_ok   = 1'b1;
    case (op_reg)
      OP_ADD: res_wide = W2'(sum);
      OP_SUB: begin
        res_wide = W2'(diff);
        res_neg  = (a_reg < b_reg);
      end
      OP_MUL: begin
        res_wide = product;
        res_ok   = mul_done;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= WAIT_A;
      ret_reg      <= WAIT_A;
      op_reg       <= OP_NONE;
      a_reg        <= '0;
      b_reg        <= '0;
      scan_val_reg <= '0;
      pos_reg      <= '0;
      neg_reg      <= 1'b0;
      fresh_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ret_reg      <= ret_next;
      op_reg       <= op_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      scan_val_reg <= scan_val_next;
      pos_reg      <= pos_next;
      neg_reg      <= neg_next;
      fresh_reg    <= fresh_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ret_next      = ret_reg;
    op_next       = op_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    scan_val_next = scan_val_reg;
    pos_next      = pos_reg;
    neg_next      = neg_reg;
    fresh_next    = fresh_reg;
    mul_start     = 1'b0;

    case (state_reg)
      WAIT_A, WAIT_B: begin
        if (key_fire) begin
          if (is_digit(cmd) || cmd == KEY_BKSP) begin
            if (in_wait_a) begin
              a_next     = entry_new;
              neg_next   = 1'b0;
              fresh_next = 1'b0;
            end else begin
              b_next = entry_new;
            end
            scan_val_next = entry_new;
            pos_next      = '0;
            ret_next      = state_reg;
            state_next    = SCAN;
          end else if (cmd == KEY_CLR) begin
            a_next        = '0;
            b_next        = '0;
            op_next       = OP_NONE;
            neg_next      = 1'b0;
            fresh_next    = 1'b0;
            scan_val_next = '0;
            pos_next      = '0;
            ret_next      = WAIT_A;
            state_next    = SCAN;
          end else if (cmd == KEY_EQ) begin
            if (!in_wait_a) begin
              state_next = CALC;
              mul_start  = (op_reg == OP_MUL);
            end
          end else begin
            op_next = key_to_op(cmd);
            if (in_wait_a) begin
              b_next     = '0;
              neg_next   = 1'b0;
              fresh_next = 1'b0;
              state_next = WAIT_B;
            end
          end
        end
      end

      CALC: begin
        if (res_ok) begin
          op_next  = OP_NONE;
          pos_next = '0;
          if (res_wide > W2'(MAX_VAL)) begin
            a_next     = '0;
            b_next     = '0;
            neg_next   = 1'b0;
            state_next = ERROR;
          end else begin
            a_next        = W'(res_wide);
            b_next        = '0;
            neg_next      = res_neg;
            fresh_next    = 1'b1;
            scan_val_next = W'(res_wide);
            ret_next      = WAIT_A;
            state_next    = SCAN;
          end
        end
      end

      // Each step divides the remaining value by ten so data is always V%10.
      SCAN: begin
        if (pos_reg == LAST_POS) begin
          pos_next   = '0;
          state_next = ret_reg;
        end else begin
          pos_next      = pos_reg + PW'(1);
          scan_val_next = scan_val_reg / TEN;
        end
      end

      ERROR: begin
        if (key_fire && cmd == KEY_CLR) begin
          a_next     = '0;
          b_next     = '0;
          op_next    = OP_NONE;
          fresh_next = 1'b0;
          state_next = WAIT_A;
        end
      end

      default: state_next = WAIT_A;
    endcase
  end

  always_comb begin
    case (state_reg)
      WAIT_A, WAIT_B: status_c = ST_READY;
      CALC:           status_c = ST_BUSY;
      SCAN:           status_c = ST_SCAN;
      default:        status_c = ST_ERR;
    endcase
  end

  assign status = status_c;
  assign data   = (state_reg == SCAN) ? 4'(scan_val_reg % TEN) : 4'd0;
  assign pos    = pos_reg;
  assign neg    = neg_reg;
  assign state  = state_reg;

endmodule

// File: tb/tb_calc_multidigit.sv
// Self-checking bench for calc_multidigit: directed key sequences followed by
// random keys, all checked against a plain-arithmetic calculator model.
module tb_calc_multidigit;
  import calc_pkg::*;

  localparam int     NDIG = 8;
  localparam int     W    = 27;
  localparam int     PW   = 3;
  localparam longint MAXV = 64'd99999999;
  localparam longint DLIM = 64'd10000000;

  logic          clock = 1'b0;
  logic          reset;
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    status;
  logic [3:0]    data;
  logic [PW-1:0] pos;
  logic          neg;
  logic [2:0]    state;

  calc_multidigit #(.NDIG(NDIG)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .status    (status),
    .data      (data),
    .pos       (pos),
    .neg       (neg),
    .state     (state)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  // Calculator model: mst 0 = entering A, 1 = entering B, 2 = error
  longint ma, mb;
  int     mop, mst;
  bit     mneg, mfresh;
  bit     e_scan;
  longint e_val;
  int     e_busy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    ma = 0; mb = 0; mop = 0; mst = 0; mneg = 0; mfresh = 0;
  endtask

  task automatic model_key(input int k);
    longint e, r;
    e_scan = 0; e_busy = 0; e_val = 0;
    if (mst == 2) begin
      if (k == 13) begin ma = 0; mb = 0; mop = 0; mfresh = 0; mst = 0; end
      return;
    end
    e = (mst == 0) ? ma : mb;
    if (k <= 9 || k == 15) begin
      if (k == 15) e = e / 10;
      else begin
        if (mst == 0 && mfresh) e = 0;
        if (e < DLIM) e = e * 10 + k;
      end
      if (mst == 0) begin ma = e; mneg = 0; mfresh = 0; end
      else mb = e;
      e_scan = 1; e_val = e;
    end else if (k == 13) begin
      ma = 0; mb = 0; mop = 0; mneg = 0; mfresh = 0; mst = 0;
      e_scan = 1; e_val = 0;
    end else if (k == 14) begin
      if (mst == 1) begin
        e_busy = (mop == 12) ? W + 1 : 1;
        mneg = 0;
        case (mop)
          10: r = ma + mb;
          11: begin r = (ma >= mb) ? ma - mb : mb - ma; mneg = (ma < mb); end
          default: r = ma * mb;
        endcase
        mop = 0;
        if (r > MAXV) begin
          mst = 2; mneg = 0; ma = 0; mb = 0;
        end else begin
          ma = r; mb = 0; mfresh = 1; mst = 0;
          e_scan = 1; e_val = r;
        end
      end
    end else begin
      mop = k;
      if (mst == 0) begin mb = 0; mneg = 0; mfresh = 0; mst = 1; end
    end
  endtask

  task automatic observe(input string tag);
    int     busy;
    longint val, p;
    state_t es;
    busy = 0;
    while (status == ST_BUSY && busy < 100) begin
      check({tag, " ready_in_calc"}, cmd_ready, 0);
      @(posedge clock); #1;
      busy++;
    end
    check({tag, " busy_cycles"}, busy, e_busy);
    if (e_scan) begin
      check({tag, " scan_status"}, status, ST_SCAN);
      check({tag, " ready_in_scan"}, cmd_ready, 0);
      val = 0; p = 1;
      for (int k = 0; k < NDIG; k++) begin
        check({tag, " pos"}, pos, k);
        val += longint'(data) * p;
        p = p * 10;
        if (k < NDIG - 1) begin @(posedge clock); #1; end
      end
      check({tag, " scan_value"}, val, e_val);
      check({tag, " scan_neg"}, neg, mneg);
      @(posedge clock); #1;
      check({tag, " post_scan_pos"}, pos, 0);
    end else begin
      check({tag, " data_idle"}, data, 0);
    end
    check({tag, " status"}, status, (mst == 2) ? ST_ERR : ST_READY);
    check({tag, " cmd_ready"}, cmd_ready, 1);
    es = (mst == 0) ? WAIT_A : (mst == 1) ? WAIT_B : ERROR;
    check({tag, " state"}, state, es);
    check({tag, " neg"}, neg, mneg);
  endtask

  task automatic press(input int k, input string tag);
    string t;
    t = $sformatf("%s k%0d", tag, k);
    @(negedge clock);
    cmd = 4'(k); cmd_valid = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    model_key(k);
    observe(t);
    $display("key %2d -> A=%0d B=%0d st=%0d neg=%0b", k, ma, mb, mst, mneg);
  endtask

  task automatic press_seq(input int keys[$], input string tag);
    foreach (keys[i]) press(keys[i], tag);
  endtask

  initial begin
    int r, k;
    reset = 1'b1; cmd = 4'd0; cmd_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset status", status, ST_READY);
    check("reset pos", pos, 0);
    check("reset data", data, 0);
    check("reset neg", neg, 0);
    check("reset ready", cmd_ready, 1);
    check("reset state", state, WAIT_A);
    @(negedge clock); reset = 1'b0;

    press_seq('{1, 2, 10, 3, 4, 14}, "add12_34");
    press_seq('{13, 5, 11, 9, 14}, "sub5_9");
    press_seq('{10, 1, 14}, "chain_add");
    press_seq('{13, 1, 2, 3, 4, 12, 5, 6, 7, 8, 14}, "mul");
    press_seq('{13, 9, 9, 9, 9, 9, 9, 9, 9, 10, 1, 14}, "ovf");
    press_seq('{5, 13}, "err_exit");
    press_seq('{1, 2, 3, 4, 5, 6, 7, 8, 9, 15}, "nine_digits");
    press_seq('{7, 14}, "eq_in_a");

    // A key without cmd_valid must be dropped.
    @(negedge clock); cmd = 4'd3; cmd_valid = 1'b0;
    @(posedge clock); #1;
    check("dropped status", status, ST_READY);
    press(4, "after_drop");

    // Reset in the middle of a multiply.
    press_seq('{13, 1, 2, 3, 4, 12, 5, 6, 7, 8}, "mul_rst");
    @(negedge clock); cmd = 4'd14; cmd_valid = 1'b1;
    @(posedge clock); #1; cmd_valid = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    check("mid_mul busy", status, ST_BUSY);
    @(negedge clock); reset = 1'b1;
    #1;
    check("mid_mul rst status", status, ST_READY);
    check("mid_mul rst pos", pos, 0);
    check("mid_mul rst state", state, WAIT_A);
    check("mid_mul rst ready", cmd_ready, 1);
    @(negedge clock); reset = 1'b0;
    model_reset();
    press_seq('{2, 10, 3, 14}, "post_rst_add");

    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 58)      k = int'($urandom_range(0, 9));
      else if (r < 70) k = int'($urandom_range(10, 12));
      else if (r < 82) k = 14;
      else if (r < 90) k = 15;
      else             k = 13;
      press(k, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
